// File: rtl/lsu_store_drain.sv
// Store-FIFO drain: issues one memory write per head entry, pops it once the write completes,
// retries errored/timed-out writes, and absorbs FIFO flushes while a write is in flight.
module lsu_store_drain #(
    parameter int ADDRW    = 32,
    parameter int DATAW    = 32,
    parameter int MAXRETRY = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                           i_Clk,
    input  logic                           i_Rest,
    input  logic                           i_FifoEmpty,
    input  logic [ADDRW+DATAW+DATAW/8-1:0] i_FifoPreOut,
    output logic                           o_Rable,
    input  logic                           i_Flush,
    output logic                           o_ReqValid,
    input  logic                           i_ReqReady,
    output logic [ADDRW-1:0]               o_ReqAddr,
    output logic [DATAW-1:0]               o_ReqData,
    output logic [DATAW/8-1:0]             o_ReqStrb,
    input  logic                           i_RespValid,
    input  logic                           i_RespErr,
    output logic                           o_Busy,
    output logic                           o_ErrSticky,
    output logic [ADDRW-1:0]               o_ErrAddr,
    output logic [15:0]                    o_DoneCnt
);

    localparam int STRBW  = DATAW / 8;
    localparam int ENTRYW = ADDRW + DATAW + STRBW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_POP,
        S_FLWAIT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ADDRW-1:0]   r_addr;
    logic [DATAW-1:0]   r_data;
    logic [STRBW-1:0]   r_strb;
    logic [2:0]         r_retry;
    logic [9:0]         r_tmo;
    logic               r_errs;
    logic [ADDRW-1:0]   r_erra;
    logic [15:0]        r_done;

    logic               w_start;
    logic               w_acc;
    logic               w_tmo_hit;
    logic               w_ok;
    logic               w_err;
    logic               w_can_retry;
    logic [ADDRW-1:0]   w_head_addr;
    logic [DATAW-1:0]   w_head_data;
    logic [STRBW-1:0]   w_head_strb;

    assign w_head_addr = i_FifoPreOut[ENTRYW-1 -: ADDRW];
    assign w_head_data = i_FifoPreOut[STRBW +: DATAW];
    assign w_head_strb = i_FifoPreOut[STRBW-1:0];

    assign w_start     = !i_FifoEmpty && !i_Flush;
    assign w_acc       = (r_state == S_REQ) && i_ReqReady;
    assign w_tmo_hit   = (r_tmo == 10'(TIMEOUT));
    assign w_ok        = i_RespValid && !i_RespErr;
    // A silent memory is treated exactly like an error response.
    assign w_err       = (i_RespValid && i_RespErr) || w_tmo_hit;
    assign w_can_retry = (r_retry < 3'(MAXRETRY));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_REQ;
            S_REQ: begin
                if (i_Flush)    w_next = w_acc ? S_FLWAIT : S_IDLE;
                else if (w_acc) w_next = S_WAIT;
            end
            S_WAIT: begin
                // A response landing in the flush cycle closes the abandoned write outright.
                if (i_Flush)    w_next = i_RespValid ? S_IDLE : S_FLWAIT;
                else if (w_ok)  w_next = S_POP;
                else if (w_err) w_next = w_can_retry ? S_REQ : S_POP;
            end
            S_POP:    w_next = S_IDLE;
            S_FLWAIT: if (i_RespValid || w_tmo_hit) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rest) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_strb  <= '0;
            r_retry <= '0;
            r_tmo   <= '0;
            r_errs  <= 1'b0;
            r_erra  <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr  <= w_head_addr;
                        r_data  <= w_head_data;
                        r_strb  <= w_head_strb;
                        r_retry <= '0;
                    end
                end
                S_REQ: begin
                    if (w_acc) r_tmo <= '0;
                end
                S_WAIT: begin
                    if (!w_tmo_hit) r_tmo <= r_tmo + 10'd1;
                    if (i_Flush) begin
                        r_tmo <= '0;
                    end else if (w_ok) begin
                        r_done <= r_done + 16'd1;
                    end else if (w_err) begin
                        if (w_can_retry) begin
                            r_retry <= r_retry + 3'd1;
                        end else if (!r_errs) begin
                            r_errs <= 1'b1;
                            r_erra <= r_addr;
                        end
                    end
                end
                S_FLWAIT: begin
                    if (!w_tmo_hit) r_tmo <= r_tmo + 10'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_Rable     = (r_state == S_POP);
    assign o_ReqValid  = (r_state == S_REQ);
    assign o_Busy      = (r_state != S_IDLE);
    assign o_ReqAddr   = r_addr;
    assign o_ReqData   = r_data;
    assign o_ReqStrb   = r_strb;
    assign o_ErrSticky = r_errs;
    assign o_ErrAddr   = r_erra;
    assign o_DoneCnt   = r_done;

endmodule

// File: tb/tb_lsu_store_drain.sv
// Directed bench for lsu_store_drain: FIFO model, optional auto-responder, immediate assertions.
module tb_lsu_store_drain;

    localparam int ADDRW  = 32;
    localparam int DATAW  = 32;
    localparam int STRBW  = 4;
    localparam int ENTRYW = ADDRW + DATAW + STRBW;
    localparam int TMO    = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_FifoEmpty;
    logic [ENTRYW-1:0] i_FifoPreOut;
    logic              o_Rable;
    logic              i_Flush;
    logic              o_ReqValid;
    logic              i_ReqReady;
    logic [ADDRW-1:0]  o_ReqAddr;
    logic [DATAW-1:0]  o_ReqData;
    logic [STRBW-1:0]  o_ReqStrb;
    logic              i_RespValid;
    logic              i_RespErr;
    logic              o_Busy;
    logic              o_ErrSticky;
    logic [ADDRW-1:0]  o_ErrAddr;
    logic [15:0]       o_DoneCnt;

    always #5 clk = ~clk;

    lsu_store_drain #(.ADDRW(ADDRW), .DATAW(DATAW), .MAXRETRY(2), .TIMEOUT(TMO)) dut (
        .i_Clk(clk), .i_Rest(rst), .i_FifoEmpty(i_FifoEmpty), .i_FifoPreOut(i_FifoPreOut),
        .o_Rable(o_Rable), .i_Flush(i_Flush), .o_ReqValid(o_ReqValid), .i_ReqReady(i_ReqReady),
        .o_ReqAddr(o_ReqAddr), .o_ReqData(o_ReqData), .o_ReqStrb(o_ReqStrb),
        .i_RespValid(i_RespValid), .i_RespErr(i_RespErr), .o_Busy(o_Busy),
        .o_ErrSticky(o_ErrSticky), .o_ErrAddr(o_ErrAddr), .o_DoneCnt(o_DoneCnt)
    );

    logic [ENTRYW-1:0] fifo[$];
    logic [ADDRW-1:0]  acc_addr[$];
    logic [DATAW-1:0]  acc_data[$];
    logic [STRBW-1:0]  acc_strb[$];
    int                acc_cyc[$];
    int                n_chk = 0;
    int                n_fail = 0;
    int                rable_cnt = 0;
    int                cyc = 0;
    bit                auto_rsp = 1'b0;
    bit                auto_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sync_fifo();
        i_FifoEmpty  = (fifo.size() == 0);
        i_FifoPreOut = (fifo.size() != 0) ? fifo[0] : '0;
    endtask

    task automatic push(input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d, input logic [STRBW-1:0] s);
        fifo.push_back({a, d, s});
        sync_fifo();
    endtask

    // One clock: log an accept in the ending cycle, then update the models for the new cycle.
    task automatic tick();
        bit acc;
        acc = (o_ReqValid === 1'b1) && (i_ReqReady === 1'b1);
        if (acc) begin
            acc_addr.push_back(o_ReqAddr);
            acc_data.push_back(o_ReqData);
            acc_strb.push_back(o_ReqStrb);
            acc_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        i_RespValid = 1'b0;
        i_RespErr   = 1'b0;
        i_Flush     = 1'b0;
        if (auto_rsp && acc) begin
            i_RespValid = 1'b1;
            i_RespErr   = auto_err;
        end
        if (o_Rable === 1'b1) begin
            rable_cnt++;
            if (fifo.size() != 0) void'(fifo.pop_front());
        end
        sync_fifo();
    endtask

    task automatic run_idle(input string tag, input int lim, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while ((o_Busy !== 1'b0 || fifo.size() != 0) && n < lim);
        chk({tag, "_idle"}, 64'(o_Busy !== 1'b0 || fifo.size() != 0), 64'd0);
    endtask

    initial begin
        int n;
        int a0;
        int r0;
        rst = 1'b1; i_Flush = 1'b0; i_ReqReady = 1'b0; i_RespValid = 1'b0; i_RespErr = 1'b0;
        sync_fifo();
        repeat (3) tick();
        chk("rst_rable", 64'(o_Rable), 64'd0);
        chk("rst_reqvalid", 64'(o_ReqValid), 64'd0);
        chk("rst_reqaddr", 64'(o_ReqAddr), 64'd0);
        chk("rst_busy", 64'(o_Busy), 64'd0);
        chk("rst_errsticky", 64'(o_ErrSticky), 64'd0);
        chk("rst_donecnt", 64'(o_DoneCnt), 64'd0);
        rst = 1'b0;
        tick();

        // 1: three back-to-back entries, immediate ready and response
        i_ReqReady = 1'b1; auto_rsp = 1'b1; auto_err = 1'b0;
        push(32'h100, 32'hA000_0100, 4'hF);
        push(32'h104, 32'hA000_0104, 4'h3);
        push(32'h108, 32'hA000_0108, 4'hC);
        run_idle("t1", 100, n);
        chk("t1_cycles", 64'(n), 64'd12);
        chk("t1_nacc", 64'(acc_addr.size()), 64'd3);
        chk("t1_addr0", 64'(acc_addr[0]), 64'h100);
        chk("t1_addr1", 64'(acc_addr[1]), 64'h104);
        chk("t1_addr2", 64'(acc_addr[2]), 64'h108);
        chk("t1_data1", 64'(acc_data[1]), 64'hA000_0104);
        chk("t1_strb2", 64'(acc_strb[2]), 64'hC);
        chk("t1_rable", 64'(rable_cnt), 64'd3);
        chk("t1_done", 64'(o_DoneCnt), 64'd3);
        chk("t1_errsticky", 64'(o_ErrSticky), 64'd0);

        // 2: ReqReady low for 5 cycles, request held stable
        i_ReqReady = 1'b0;
        a0 = acc_addr.size();
        push(32'h180, 32'hCAFE_0180, 4'h5);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 64'(o_ReqValid), 64'd1);
            chk("t2_hold_addr", 64'(o_ReqAddr), 64'h180);
            chk("t2_hold_data", 64'(o_ReqData), 64'hCAFE_0180);
            chk("t2_hold_strb", 64'(o_ReqStrb), 64'h5);
            tick();
        end
        i_ReqReady = 1'b1;
        chk("t2_valid", 64'(o_ReqValid), 64'd1);
        run_idle("t2", 100, n);
        chk("t2_nacc", 64'(acc_addr.size() - a0), 64'd1);
        chk("t2_done", 64'(o_DoneCnt), 64'd4);
        chk("t2_rable", 64'(rable_cnt), 64'd4);

        // 3: error on every response -> 3 issues then drop
        auto_err = 1'b1;
        a0 = acc_addr.size(); r0 = rable_cnt;
        push(32'h200, 32'h2222_2222, 4'hF);
        run_idle("t3", 100, n);
        chk("t3_cycles", 64'(n), 64'd8);
        chk("t3_nacc", 64'(acc_addr.size() - a0), 64'd3);
        chk("t3_retry_addr", 64'(acc_addr[a0+2]), 64'h200);
        chk("t3_rable", 64'(rable_cnt - r0), 64'd1);
        chk("t3_errsticky", 64'(o_ErrSticky), 64'd1);
        chk("t3_erraddr", 64'(o_ErrAddr), 64'h200);
        chk("t3_done", 64'(o_DoneCnt), 64'd4);
        a0 = acc_addr.size();
        push(32'h300, 32'h3333_3333, 4'hF);
        run_idle("t3b", 100, n);
        chk("t3b_nacc", 64'(acc_addr.size() - a0), 64'd3);
        chk("t3b_erraddr", 64'(o_ErrAddr), 64'h200);
        auto_err = 1'b0;
        push(32'h400, 32'h4444_4444, 4'hF);
        run_idle("t3c", 100, n);
        chk("t3c_done", 64'(o_DoneCnt), 64'd5);

        // 5: flush while WAIT, response 3 cycles later
        auto_rsp = 1'b0; r0 = rable_cnt;
        push(32'h600, 32'h6666_6666, 4'hF);
        tick();
        tick();
        i_Flush = 1'b1; fifo.delete(); sync_fifo();
        tick();
        chk("t5_flwait_busy", 64'(o_Busy), 64'd1);
        chk("t5_flwait_reqvalid", 64'(o_ReqValid), 64'd0);
        tick();
        tick();
        chk("t5_prersp_busy", 64'(o_Busy), 64'd1);
        i_RespValid = 1'b1;
        tick();
        chk("t5_busy", 64'(o_Busy), 64'd0);
        chk("t5_rable", 64'(rable_cnt - r0), 64'd0);
        chk("t5_done", 64'(o_DoneCnt), 64'd5);

        // flush in REQ before acceptance
        i_ReqReady = 1'b0;
        push(32'h610, 32'h6161_6161, 4'hF);
        tick();
        chk("fr_reqvalid", 64'(o_ReqValid), 64'd1);
        i_Flush = 1'b1; fifo.delete(); sync_fifo();
        tick();
        chk("fr_reqvalid_drop", 64'(o_ReqValid), 64'd0);
        chk("fr_busy", 64'(o_Busy), 64'd0);
        i_ReqReady = 1'b1;

        // flush in POP still pops
        auto_rsp = 1'b1;
        push(32'h800, 32'h8888_8888, 4'hF);
        tick();
        tick();
        tick();
        chk("fp_rable", 64'(o_Rable), 64'd1);
        i_Flush = 1'b1;
        tick();
        chk("fp_busy", 64'(o_Busy), 64'd0);
        chk("fp_rable_end", 64'(o_Rable), 64'd0);
        chk("fp_done", 64'(o_DoneCnt), 64'd6);

        // 6: reset mid-WAIT, late response ignored
        auto_rsp = 1'b0;
        push(32'h700, 32'h7777_7777, 4'hA);
        tick();
        tick();
        tick();
        chk("t6_wait_busy", 64'(o_Busy), 64'd1);
        rst = 1'b1;
        tick();
        chk("t6_rable", 64'(o_Rable), 64'd0);
        chk("t6_reqvalid", 64'(o_ReqValid), 64'd0);
        chk("t6_reqaddr", 64'(o_ReqAddr), 64'd0);
        chk("t6_reqdata", 64'(o_ReqData), 64'd0);
        chk("t6_reqstrb", 64'(o_ReqStrb), 64'd0);
        chk("t6_busy", 64'(o_Busy), 64'd0);
        chk("t6_errsticky", 64'(o_ErrSticky), 64'd0);
        chk("t6_erraddr", 64'(o_ErrAddr), 64'd0);
        chk("t6_done", 64'(o_DoneCnt), 64'd0);
        rst = 1'b0; fifo.delete(); sync_fifo();
        i_RespValid = 1'b1;
        tick();
        tick();
        chk("t6_late_busy", 64'(o_Busy), 64'd0);
        chk("t6_late_done", 64'(o_DoneCnt), 64'd0);

        // 4: no response ever -> timeout retries then drop
        a0 = acc_addr.size(); r0 = rable_cnt;
        push(32'h500, 32'h5555_5555, 4'hF);
        run_idle("t4", 2000, n);
        chk("t4_nacc", 64'(acc_addr.size() - a0), 64'd3);
        if (acc_cyc.size() >= a0 + 2)
            chk("t4_tmo_gap", 64'((acc_cyc[a0+1] - acc_cyc[a0]) inside {TMO+1, TMO+2}), 64'd1);
        chk("t4_rable", 64'(rable_cnt - r0), 64'd1);
        chk("t4_errsticky", 64'(o_ErrSticky), 64'd1);
        chk("t4_erraddr", 64'(o_ErrAddr), 64'h500);
        chk("t4_done", 64'(o_DoneCnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
